// File: rtl/csub_comb_if.sv
`default_nettype none
// ============================================================================
// Module   : csub_comb_if
// Brief    : Input/output stream bundle for csub_comb (valid/ready both sides).
//            sat_flag exists only when CSUB_COMB_SAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface csub_comb_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_real;
    logic signed [DATA_WIDTH-1:0] in_imag;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_real;
    logic signed [DATA_WIDTH-1:0] out_imag;
    logic                         out_primed;
`ifdef CSUB_COMB_SAT_EN
    logic                         sat_flag;

    modport master (
        output in_valid, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_primed, sat_flag
    );

    modport slave (
        input  in_valid, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_primed, sat_flag
    );
`else
    modport master (
        output in_valid, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_primed
    );

    modport slave (
        input  in_valid, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_primed
    );
`endif
endinterface
`default_nettype wire

// File: rtl/csub_comb.sv
`default_nettype none
// ============================================================================
// Module   : csub_comb
// Brief    : Streaming complex comb y[n] = x[n] - x[n-DELAY], valid/ready.
//            Define CSUB_COMB_SAT_EN for saturating subtraction and sat_flag.
// Revision : 1.0 - initial release
// ============================================================================
module csub_comb #(
    parameter int DATA_WIDTH = 16,
    parameter int DELAY      = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  clr,
    csub_comb_if.slave bus
);
    localparam int c_PTR_W = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DELAY - 1);

    localparam logic [0:0] c_S_PRIME = 1'b0;
    localparam logic [0:0] c_S_RUN   = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [c_PTR_W-1:0]    r_wp;
    logic [c_PTR_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_buf_re [DELAY];
    logic [DATA_WIDTH-1:0] r_buf_im [DELAY];

    logic                  w_in_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_hist_re;
    logic [DATA_WIDTH-1:0] w_hist_im;
    logic [DATA_WIDTH-1:0] w_res_re;
    logic [DATA_WIDTH-1:0] w_res_im;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_re;
    logic [DATA_WIDTH-1:0] r_out_im;
    logic                  r_out_primed;

    assign w_in_ready = ~r_out_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;

    // Buffer is zero while priming anyway; the gate makes the zero history explicit.
    assign w_hist_re = (r_state == c_S_RUN) ? r_buf_re[r_wp] : '0;
    assign w_hist_im = (r_state == c_S_RUN) ? r_buf_im[r_wp] : '0;

`ifdef CSUB_COMB_SAT_EN
    logic w_ovf_re;
    logic w_ovf_im;
    logic r_sat;

    // Returns {overflow, clamped difference} using one guard bit.
    function automatic logic [DATA_WIDTH:0] f_sub_sat(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] ext;
        ext = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
        if (ext[DATA_WIDTH] != ext[DATA_WIDTH-1]) begin
            f_sub_sat = {1'b1, ext[DATA_WIDTH], {(DATA_WIDTH-1){~ext[DATA_WIDTH]}}};
        end else begin
            f_sub_sat = {1'b0, ext[DATA_WIDTH-1:0]};
        end
    endfunction

    assign {w_ovf_re, w_res_re} = f_sub_sat(bus.in_real, w_hist_re);
    assign {w_ovf_im, w_res_im} = f_sub_sat(bus.in_imag, w_hist_im);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (clr) begin
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_sat <= w_ovf_re | w_ovf_im;
        end
    end

    assign bus.sat_flag = r_sat;
`else
    assign w_res_re = bus.in_real - w_hist_re;
    assign w_res_im = bus.in_imag - w_hist_im;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_PRIME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = c_S_PRIME;
        end else if ((r_state == c_S_PRIME) && w_accept && (r_cnt == c_LAST)) begin
            w_state_nxt = c_S_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp         <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_re     <= '0;
            r_out_im     <= '0;
            r_out_primed <= 1'b0;
            for (int i = 0; i < DELAY; i++) begin
                r_buf_re[i] <= '0;
                r_buf_im[i] <= '0;
            end
        end else if (clr) begin
            // A simultaneous accept and any pending output are both dropped.
            r_wp         <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_re     <= '0;
            r_out_im     <= '0;
            r_out_primed <= 1'b0;
            for (int i = 0; i < DELAY; i++) begin
                r_buf_re[i] <= '0;
                r_buf_im[i] <= '0;
            end
        end else if (w_accept) begin
            r_buf_re[r_wp] <= bus.in_real;
            r_buf_im[r_wp] <= bus.in_imag;
            r_wp           <= (r_wp == c_LAST) ? '0 : r_wp + 1'b1;
            if ((r_state == c_S_PRIME) && (r_cnt != c_LAST)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_out_valid  <= 1'b1;
            r_out_re     <= w_res_re;
            r_out_im     <= w_res_im;
            r_out_primed <= (r_state == c_S_RUN);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_real   = r_out_re;
    assign bus.out_imag   = r_out_im;
    assign bus.out_primed = r_out_primed;

endmodule
`default_nettype wire

// File: doc/csub_comb.md
Name: csub_comb

Overview:
- Streaming complex comb/differencer. Computes y[n] = x[n] - x[n-DELAY] on a complex sample stream.
- Inverse-direction companion to the complex adder/integrator path: it undoes a DELAY-deep complex accumulation.
- Sits between a sample source and downstream DSP stages, with a valid/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 16, bit width of each real/imag component (two's complement).
- DELAY, 4, comb delay in accepted samples; legal range 1..256.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- clr  input  1  synchronous flush of delay line, pipeline and priming state.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_real  input  DATA_WIDTH  signed input real part.
- in_imag  input  DATA_WIDTH  signed input imaginary part.
- out_valid  output  1  output sample valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out_real  output  DATA_WIDTH  signed difference, real part.
- out_imag  output  DATA_WIDTH  signed difference, imaginary part.
- out_primed  output  1  high when the current output used a true x[n-DELAY], i.e. not a zero-history sample.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_real=0, out_imag=0, out_primed=0.
  - Delay line cleared to 0, write pointer=0, prime counter=0, state=PRIME.
- Handshake:
  - in_ready = ~out_valid | out_ready. Combinational, with no dependency on in_valid.
  - An input is accepted when in_valid & in_ready.
  - An output transfers when out_valid & out_ready.
  - Output holds stable while out_valid=1 and out_ready=0.
- Latency:
  - Exactly 1 cycle from accept to out_valid.
  - Full throughput of 1 sample/cycle when out_ready is held high.
- Delay line:
  - DELAY-entry circular buffer per component, single write pointer.
  - On accept: read entry[wp] as x[n-DELAY], write the new sample to entry[wp], then advance wp.
  - wp wraps from DELAY-1 to 0.
- Arithmetic:
  - out_real = in_real - entry_real, out_imag = in_imag - entry_imag.
  - Modulo 2^DATA_WIDTH (wrap-around) by default; no width growth.
- State machine:
  - PRIME: prime counter counts accepted samples. out_primed=0 on outputs generated here; history reads as 0. After the DELAY-th accept, transition to RUN.
  - RUN: out_primed=1 on every generated output. The block stays in RUN until clr or rst.
- Flush (clr=1):
  - Next edge: buffer zeroed, wp=0, counter=0, state=PRIME, out_valid=0.
  - clr has priority over a simultaneous accept, which is dropped (in_ready still shows the pre-clr value).
  - clr also has priority over a pending output, which is discarded.
- Simultaneous output transfer and new accept in one cycle: the output register reloads with the new result, with no bubble.
- Reset mid-stream: all state is lost immediately and the block restarts in PRIME.

Optional Feature:
- Macro: CSUB_COMB_SAT_EN.
- Defined: subtraction is saturating per component.
  - Positive overflow clamps to 2^(DATA_WIDTH-1)-1; negative overflow clamps to -2^(DATA_WIDTH-1).
  - Adds output sat_flag (1 bit, reset 0), registered alongside the data, high if either component saturated.
- Undefined: wrap-around arithmetic and no sat_flag port.

Test Plan:
- Reset then stream x = (1+1j),(2+2j),...,(8+8j) with DELAY=4 and out_ready=1 -> outputs (1,1),(2,2),(3,3),(4,4) with out_primed=0, then (4,4) x4 with out_primed=1; out_valid one cycle after each accept.
- Backpressure: out_ready=0 for 3 cycles mid-stream -> in_ready=0 while out_valid=1, output held constant, no sample lost or duplicated; sequence matches the no-stall run.
- Wrap arithmetic, DATA_WIDTH=16, DELAY=1: x0=-32768 then x1=32767 (real) -> second output = -1 (wraps). With CSUB_COMB_SAT_EN: 32767 and sat_flag=1.
- clr asserted on the same cycle as the 6th accept, DELAY=4 -> that sample is dropped, out_valid=0 next cycle; the next input 5+5j produces (5,5) with out_primed=0.
- Async rst pulsed mid-cycle during RUN -> outputs go to 0 immediately without a clock edge; the stream then restarts in PRIME.
- DELAY=1, continuous ramp 0,1,2,... on real -> outputs 0,1,1,1,... and out_primed=1 from the second output on.
